inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the SingleClockMIPS instruction-memory write port (W_Ins/WE); on the board that port is otherwise tied off.
- The operator enters a program one byte at a time from switches, confirming each byte with a debounced button.
- The block assembles 32-bit words MSB-first and issues one single-cycle WE pulse per completed word, until DEPTH words have been written.
- Inputs come from BTN_IN outputs and SW; progress outputs feed the display SELECTOR/SEG7DEC path.

Parameters:
- DEPTH, 64, number of instruction words the memory accepts; the loader locks once this many words are written.
- CNT_W, 7, width of word_cnt; must satisfy 2^CNT_W > DEPTH.

Ports:
- CLK  input  1  system clock (MAX10_CLK1_50 domain).
- RST  input  1  synchronous, active-high reset.
- DIN  input  8  byte value to load (SW[7:0]).
- byte_stb  input  1  level from BTN_IN; each rising edge commits DIN as one byte.
- clr_stb  input  1  level from BTN_IN; each rising edge restarts loading.
- W_Ins  output  32  assembled instruction word, to SingleClockMIPS W_Ins.
- WE  output  1  single-cycle write enable, to SingleClockMIPS WE.
- byte_idx  output  2  number of bytes already held in the current partial word (0..3).
- word_cnt  output  CNT_W  number of words written since reset/clear.
- full  output  1  high once DEPTH words have been written.
- partial  output  32  shift register contents, for display.

Behaviour:
- Edge detection: internal registers hold the previous byte_stb and clr_stb values. An event occurs in cycle n if the strobe is 1 in cycle n and was 0 in cycle n-1. Prev registers reset to 0, so a strobe held high through reset produces an event in the first cycle after reset.
- States: COLLECT, WRITE, FULL.
- Reset (RST=1 at an edge): state=COLLECT; W_Ins=0; WE=0; byte_idx=0; word_cnt=0; full=0; partial=0; prev strobe registers=0.
- COLLECT, on a byte event at an edge:
  - partial <= {partial[23:0], DIN}.
  - If byte_idx<3: byte_idx++.
  - If byte_idx==3: W_Ins <= {partial[23:0], DIN}; byte_idx <= 0; state <= WRITE.
- WRITE lasts exactly one cycle:
  - WE = (state==WRITE), decoded from state register; glitch-free, no other source.
  - At the end of the cycle: word_cnt++; partial <= 0.
  - Next state is FULL if the incremented word_cnt==DEPTH, else COLLECT.
- Latency: WE is high in the cycle after the edge that captures the 4th byte. W_Ins is stable from that edge until the next word completes.
- A byte event during WRITE or FULL is discarded; its edge is consumed, not queued.
- FULL: full=1; WE stays 0; only a clear event or RST leaves FULL.
- Clear event, any state, has priority over a simultaneous byte event:
  - partial=0; byte_idx=0; word_cnt=0; W_Ins=0; full=0; state=COLLECT.
  - A clear in the WRITE cycle does not suppress that cycle's WE (word is written), but word_cnt ends at 0, not incremented.
- The loader does not rewind the memory's write pointer; system-level restart requires RST, which is shared with SingleClockMIPS.
- RST asserted mid-word or in WRITE: the partial word is discarded and the WE of that cycle is still decoded from the pre-reset state. RST has priority over all events.
- Counting: word_cnt never exceeds DEPTH; it does not wrap.

Optional Feature:
- Macro: INST_LOADER_CHKSUM_EN.
- Defined:
  - Adds output chksum [7:0], reset/cleared to 0.
  - On every accepted byte event: chksum <= chksum + DIN (mod 256).
  - Discarded bytes (WRITE/FULL) do not contribute.
  - Lets the operator verify the entered program against the assembler listing.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- Reset, then bytes 0x20,0x08,0x00,0x05 -> byte_idx steps 1,2,3,0; WE=1 for exactly one cycle one clock after the 4th event; W_Ins=0x20080005; word_cnt=1.
- byte_stb held high 100 cycles -> exactly one byte accepted (byte_idx=1).
- DEPTH=2 override, 8 bytes, then 4 more -> two WE pulses; full=1; word_cnt=2; the last 4 bytes are ignored with no WE and partial=0.
- Two bytes 0xAA,0xBB, then clr_stb and byte_stb rising in the same cycle -> byte_idx=0, partial=0, word_cnt=0; the byte is not accepted.
- 4th byte event with a byte event in the WRITE cycle -> that byte is discarded; byte_idx=0 after WRITE.
- INST_LOADER_CHKSUM_EN: bytes 0xFF,0x02 -> chksum=0x01; after a clear -> chksum=0x00.

Source files
------------

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Purpose  : Byte-wise instruction loader; assembles MSB-first 32-bit words
//            and pulses WE once per word. Optional: INST_LOADER_CHKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
module inst_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       DIN,
  input  logic             byte_stb,
  input  logic             clr_stb,
  output logic [31:0]      W_Ins,
  output logic             WE,
  output logic [1:0]       byte_idx,
  output logic [CNT_W-1:0] word_cnt,
  output logic             full,
  output logic [31:0]      partial
`ifdef INST_LOADER_CHKSUM_EN
  ,
  output logic [7:0]       chksum
`endif
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             prev_byte;
  logic             prev_clr;
  logic             byte_ev;
  logic             clr_ev;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;

  assign byte_ev = byte_stb & ~prev_byte;
  assign clr_ev  = clr_stb & ~prev_clr;
  assign accept  = byte_ev && (state == S_COLLECT);
  assign cnt_inc = word_cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr_ev) begin
      state_nxt = S_COLLECT;
    end else begin
      case (state)
        S_COLLECT: if (accept && (byte_idx == 2'd3)) state_nxt = S_WRITE;
        S_WRITE:   state_nxt = (cnt_inc == CNT_W'(DEPTH)) ? S_FULL : S_COLLECT;
        S_FULL:    state_nxt = S_FULL;
        default:   state_nxt = S_COLLECT;
      endcase
    end
  end

  // Outputs decode straight from the state register so WE cannot glitch.
  always_comb begin
    WE   = (state == S_WRITE);
    full = (state == S_FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_byte <= 1'b0;
      prev_clr  <= 1'b0;
      partial   <= 32'd0;
      W_Ins     <= 32'd0;
      byte_idx  <= 2'd0;
      word_cnt  <= '0;
    end else begin
      prev_byte <= byte_stb;
      prev_clr  <= clr_stb;
      if (clr_ev) begin
        partial  <= 32'd0;
        W_Ins    <= 32'd0;
        byte_idx <= 2'd0;
        word_cnt <= '0;
      end else if (state == S_WRITE) begin
        word_cnt <= cnt_inc;
        partial  <= 32'd0;
      end else if (accept) begin
        partial <= {partial[23:0], DIN};
        if (byte_idx == 2'd3) begin
          W_Ins    <= {partial[23:0], DIN};
          byte_idx <= 2'd0;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

`ifdef INST_LOADER_CHKSUM_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      chksum <= 8'd0;
    end else if (clr_ev) begin
      chksum <= 8'd0;
    end else if (accept) begin
      chksum <= chksum + DIN;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_loader
// Purpose  : Self-checking bench for inst_loader (default and DEPTH=2 builds).
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  DIN = 8'd0;
  logic        byte_stb = 1'b0;
  logic        clr_stb = 1'b0;

  logic [31:0] W_Ins, partial;
  logic        WE, full;
  logic [1:0]  byte_idx;
  logic [6:0]  word_cnt;
  logic [31:0] W_Ins2, partial2;
  logic        WE2, full2;
  logic [1:0]  byte_idx2;
  logic [2:0]  word_cnt2;
`ifdef INST_LOADER_CHKSUM_EN
  logic [7:0]  chksum, chksum2;
`endif

  int checks = 0;
  int errors = 0;
  int we_pulses = 0;
  int we2_pulses = 0;

  always #5 CLK = ~CLK;

  inst_loader u_dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .byte_stb(byte_stb), .clr_stb(clr_stb),
    .W_Ins(W_Ins), .WE(WE), .byte_idx(byte_idx), .word_cnt(word_cnt),
    .full(full), .partial(partial)
`ifdef INST_LOADER_CHKSUM_EN
    , .chksum(chksum)
`endif
  );

  inst_loader #(.DEPTH(2), .CNT_W(3)) u_d2 (
    .CLK(CLK), .RST(RST), .DIN(DIN), .byte_stb(byte_stb), .clr_stb(clr_stb),
    .W_Ins(W_Ins2), .WE(WE2), .byte_idx(byte_idx2), .word_cnt(word_cnt2),
    .full(full2), .partial(partial2)
`ifdef INST_LOADER_CHKSUM_EN
    , .chksum(chksum2)
`endif
  );

  // WE is sampled mid-cycle so every high cycle counts once.
  always @(negedge CLK) begin
    if (WE)  we_pulses++;
    if (WE2) we2_pulses++;
  end

  typedef struct {
    logic        rst;
    logic [7:0]  din;
    logic        bs;
    logic        cs;
    logic [1:0]  idx;
    logic        we;
    logic [6:0]  cnt;
    logic [31:0] part;
    logic [31:0] wins;
    logic [7:0]  ck;
  } vec_t;

  vec_t tbl [39];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    DIN = b;
    byte_stb = 1'b1;
    @(negedge CLK);
    byte_stb = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_clear();
    @(negedge CLK);
    clr_stb = 1'b1;
    @(negedge CLK);
    clr_stb = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //          rst  din    bs    cs    idx   we    cnt   partial        W_Ins          ck
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[1]  = '{1'b0, 8'h20, 1'b1, 1'b0, 2'd1, 1'b0, 7'd0, 32'h00000020, 32'h00000000, 8'h20};
    tbl[2]  = '{1'b0, 8'h20, 1'b0, 1'b0, 2'd1, 1'b0, 7'd0, 32'h00000020, 32'h00000000, 8'h20};
    tbl[3]  = '{1'b0, 8'h08, 1'b1, 1'b0, 2'd2, 1'b0, 7'd0, 32'h00002008, 32'h00000000, 8'h28};
    tbl[4]  = '{1'b0, 8'h08, 1'b0, 1'b0, 2'd2, 1'b0, 7'd0, 32'h00002008, 32'h00000000, 8'h28};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 1'b0, 7'd0, 32'h00200800, 32'h00000000, 8'h28};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0, 7'd0, 32'h00200800, 32'h00000000, 8'h28};
    tbl[7]  = '{1'b0, 8'h05, 1'b1, 1'b0, 2'd0, 1'b1, 7'd0, 32'h20080005, 32'h20080005, 8'h2D};
    tbl[8]  = '{1'b0, 8'h05, 1'b0, 1'b0, 2'd0, 1'b0, 7'd1, 32'h00000000, 32'h20080005, 8'h2D};
    tbl[9]  = '{1'b0, 8'h11, 1'b1, 1'b0, 2'd1, 1'b0, 7'd1, 32'h00000011, 32'h20080005, 8'h3E};
    tbl[10] = '{1'b0, 8'h11, 1'b0, 1'b0, 2'd1, 1'b0, 7'd1, 32'h00000011, 32'h20080005, 8'h3E};
    tbl[11] = '{1'b0, 8'h22, 1'b1, 1'b0, 2'd2, 1'b0, 7'd1, 32'h00001122, 32'h20080005, 8'h60};
    tbl[12] = '{1'b0, 8'h22, 1'b0, 1'b0, 2'd2, 1'b0, 7'd1, 32'h00001122, 32'h20080005, 8'h60};
    tbl[13] = '{1'b0, 8'h33, 1'b1, 1'b0, 2'd3, 1'b0, 7'd1, 32'h00112233, 32'h20080005, 8'h93};
    tbl[14] = '{1'b0, 8'h33, 1'b0, 1'b0, 2'd3, 1'b0, 7'd1, 32'h00112233, 32'h20080005, 8'h93};
    tbl[15] = '{1'b0, 8'h44, 1'b1, 1'b0, 2'd0, 1'b1, 7'd1, 32'h11223344, 32'h11223344, 8'hD7};
    // Strobe stays high through the WRITE cycle: nothing is accepted.
    tbl[16] = '{1'b0, 8'h55, 1'b1, 1'b0, 2'd0, 1'b0, 7'd2, 32'h00000000, 32'h11223344, 8'hD7};
    tbl[17] = '{1'b0, 8'h55, 1'b0, 1'b0, 2'd0, 1'b0, 7'd2, 32'h00000000, 32'h11223344, 8'hD7};
    tbl[18] = '{1'b0, 8'h66, 1'b1, 1'b0, 2'd1, 1'b0, 7'd2, 32'h00000066, 32'h11223344, 8'h3D};
    tbl[19] = '{1'b0, 8'h66, 1'b0, 1'b1, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[20] = '{1'b0, 8'h66, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[21] = '{1'b0, 8'hAA, 1'b1, 1'b0, 2'd1, 1'b0, 7'd0, 32'h000000AA, 32'h00000000, 8'hAA};
    tbl[22] = '{1'b0, 8'hAA, 1'b0, 1'b0, 2'd1, 1'b0, 7'd0, 32'h000000AA, 32'h00000000, 8'hAA};
    tbl[23] = '{1'b0, 8'hBB, 1'b1, 1'b0, 2'd2, 1'b0, 7'd0, 32'h0000AABB, 32'h00000000, 8'h65};
    tbl[24] = '{1'b0, 8'hBB, 1'b0, 1'b0, 2'd2, 1'b0, 7'd0, 32'h0000AABB, 32'h00000000, 8'h65};
    // Clear and byte rising together: clear wins, byte dropped.
    tbl[25] = '{1'b0, 8'hCC, 1'b1, 1'b1, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[26] = '{1'b0, 8'hCC, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[27] = '{1'b0, 8'h01, 1'b1, 1'b0, 2'd1, 1'b0, 7'd0, 32'h00000001, 32'h00000000, 8'h01};
    tbl[28] = '{1'b0, 8'h01, 1'b0, 1'b0, 2'd1, 1'b0, 7'd0, 32'h00000001, 32'h00000000, 8'h01};
    tbl[29] = '{1'b0, 8'h02, 1'b1, 1'b0, 2'd2, 1'b0, 7'd0, 32'h00000102, 32'h00000000, 8'h03};
    tbl[30] = '{1'b0, 8'h02, 1'b0, 1'b0, 2'd2, 1'b0, 7'd0, 32'h00000102, 32'h00000000, 8'h03};
    tbl[31] = '{1'b0, 8'h03, 1'b1, 1'b0, 2'd3, 1'b0, 7'd0, 32'h00010203, 32'h00000000, 8'h06};
    tbl[32] = '{1'b0, 8'h03, 1'b0, 1'b0, 2'd3, 1'b0, 7'd0, 32'h00010203, 32'h00000000, 8'h06};
    tbl[33] = '{1'b0, 8'h04, 1'b1, 1'b0, 2'd0, 1'b1, 7'd0, 32'h01020304, 32'h01020304, 8'h0A};
    // Clear during WRITE: the word is still written but the count stays 0.
    tbl[34] = '{1'b0, 8'h04, 1'b0, 1'b1, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[35] = '{1'b0, 8'h04, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[36] = '{1'b0, 8'h09, 1'b1, 1'b0, 2'd1, 1'b0, 7'd0, 32'h00000009, 32'h00000000, 8'h09};
    tbl[37] = '{1'b1, 8'h09, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};
    tbl[38] = '{1'b0, 8'h09, 1'b0, 1'b0, 2'd0, 1'b0, 7'd0, 32'h00000000, 32'h00000000, 8'h00};

    for (int i = 0; i < 39; i++) begin
      @(negedge CLK);
      RST      = tbl[i].rst;
      DIN      = tbl[i].din;
      byte_stb = tbl[i].bs;
      clr_stb  = tbl[i].cs;
      @(posedge CLK);
      #1;
      check($sformatf("row%0d byte_idx", i), {30'd0, byte_idx}, {30'd0, tbl[i].idx});
      check($sformatf("row%0d WE", i), {31'd0, WE}, {31'd0, tbl[i].we});
      check($sformatf("row%0d word_cnt", i), {25'd0, word_cnt}, {25'd0, tbl[i].cnt});
      check($sformatf("row%0d partial", i), partial, tbl[i].part);
      check($sformatf("row%0d W_Ins", i), W_Ins, tbl[i].wins);
      check($sformatf("row%0d full", i), {31'd0, full}, 32'd0);
`ifdef INST_LOADER_CHKSUM_EN
      check($sformatf("row%0d chksum", i), {24'd0, chksum}, {24'd0, tbl[i].ck});
`endif
    end

    // Level held for 100 cycles counts as a single byte.
    @(negedge CLK);
    DIN = 8'h7F;
    byte_stb = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    check("held byte_idx", {30'd0, byte_idx}, 32'd1);
    check("held partial", partial, 32'h0000007F);
    @(negedge CLK);
    byte_stb = 1'b0;
    pulse_clear();
    check("clr byte_idx", {30'd0, byte_idx}, 32'd0);

    // DEPTH=2 instance fills up, then ignores further bytes.
    we_pulses = 0;
    we2_pulses = 0;
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    check("d2 WE pulses", we2_pulses, 2);
    check("d2 full", {31'd0, full2}, 32'd1);
    check("d2 word_cnt", {29'd0, word_cnt2}, 32'd2);
    check("d2 W_Ins", W_Ins2, 32'h05060708);
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
    check("d2 WE after full", we2_pulses, 2);
    check("d2 partial after full", partial2, 32'd0);
    check("d2 byte_idx after full", {30'd0, byte_idx2}, 32'd0);
    check("d2 still full", {31'd0, full2}, 32'd1);
    check("d2 W_Ins held", W_Ins2, 32'h05060708);
    check("dflt WE pulses", we_pulses, 3);
    check("dflt word_cnt", {25'd0, word_cnt}, 32'd3);
    check("dflt not full", {31'd0, full}, 32'd0);
    pulse_clear();
    check("d2 clr full", {31'd0, full2}, 32'd0);
    check("d2 clr word_cnt", {29'd0, word_cnt2}, 32'd0);
    send_byte(8'h3C);
    check("d2 byte after clr", partial2, 32'h0000003C);
    pulse_clear();

`ifdef INST_LOADER_CHKSUM_EN
    send_byte(8'hFF);
    send_byte(8'h02);
    check("chksum FF+02", {24'd0, chksum}, 32'h01);
    pulse_clear();
    check("chksum clr", {24'd0, chksum}, 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
